// File: rtl/iob_host_arb_if.sv
// Bundle of the per-channel IOb host ports and the shared IOb manager port.
// The arbiter attaches through the slave modport; the environment uses master.
interface iob_host_arb_if #(
  parameter int N_CH   = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [N_CH-1:0]            s_avalid_i;
  logic [N_CH*ADDR_W-1:0]     s_addr_i;
  logic [N_CH*DATA_W-1:0]     s_wdata_i;
  logic [N_CH*DATA_W/8-1:0]   s_wstrb_i;
  logic [N_CH*DATA_W-1:0]     s_rdata_o;
  logic [N_CH-1:0]            s_ready_o;
  logic [N_CH-1:0]            s_rvalid_o;
  logic                       m_avalid_o;
  logic [ADDR_W-1:0]          m_addr_o;
  logic [DATA_W-1:0]          m_wdata_o;
  logic [DATA_W/8-1:0]        m_wstrb_o;
  logic [DATA_W-1:0]          m_rdata_i;
  logic                       m_rvalid_i;
  logic                       m_ready_i;

  modport slave (
    input  s_avalid_i, s_addr_i, s_wdata_i, s_wstrb_i, m_rdata_i, m_rvalid_i, m_ready_i,
    output s_rdata_o, s_ready_o, s_rvalid_o, m_avalid_o, m_addr_o, m_wdata_o, m_wstrb_o
  );

  modport master (
    output s_avalid_i, s_addr_i, s_wdata_i, s_wstrb_i, m_rdata_i, m_rvalid_i, m_ready_i,
    input  s_rdata_o, s_ready_o, s_rvalid_o, m_avalid_o, m_addr_o, m_wdata_o, m_wstrb_o
  );
endinterface

// File: rtl/iob_host_arb.sv
// Round-robin arbiter funnelling N_CH IOb host channels onto one IOb manager port.
// Define IOB_HOST_ARB_TIMEOUT_EN to add the read watchdog and the sticky err_o flag.
module iob_host_arb #(
  parameter int N_CH        = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic          clk_i,
  input  logic          arst_i,
  iob_host_arb_if.slave bus,
  output logic          err_o
);
  localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int SW = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD} state_t;

  state_t            state_reg, state_next;
  logic [GW-1:0]     g_reg, g_next, p_reg, p_next, pick;
  logic              found;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic [SW-1:0]     g_wstrb;
  logic              req_active, rd_done, timeout;
  logic [DATA_W-1:0] rd_data;

  assign g_addr  = bus.s_addr_i[int'(g_reg)*ADDR_W +: ADDR_W];
  assign g_wdata = bus.s_wdata_i[int'(g_reg)*DATA_W +: DATA_W];
  assign g_wstrb = bus.s_wstrb_i[int'(g_reg)*SW +: SW];

  // First requesting channel found walking upward from the pointer, wrapping at N_CH.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && bus.s_avalid_i[(int'(p_reg) + i) % N_CH]) begin
        pick  = GW'((int'(p_reg) + i) % N_CH);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_reg <= IDLE;
      g_reg     <= '0;
      p_reg     <= '0;
    end else begin
      state_reg <= state_next;
      g_reg     <= g_next;
      p_reg     <= p_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    g_next     = g_reg;
    p_next     = p_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          g_next     = pick;
          state_next = REQ;
        end
      end
      REQ: begin
        if (!bus.s_avalid_i[g_reg]) begin
          state_next = IDLE;
        end else if (bus.m_ready_i) begin
          p_next     = (g_reg == GW'(N_CH - 1)) ? '0 : g_reg + 1'b1;
          state_next = (g_wstrb == '0) ? WAIT_RD : IDLE;
        end
      end
      WAIT_RD: begin
        if (rd_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A host withdrawing its request in REQ drops m_avalid_o in that same cycle.
  assign req_active     = (state_reg == REQ) && bus.s_avalid_i[g_reg];
  assign rd_done        = (state_reg == WAIT_RD) && (bus.m_rvalid_i || timeout);
  assign rd_data        = bus.m_rvalid_i ? bus.m_rdata_i : '1;

  assign bus.m_avalid_o = req_active;
  assign bus.m_addr_o   = (state_reg == REQ) ? g_addr  : '0;
  assign bus.m_wdata_o  = (state_reg == REQ) ? g_wdata : '0;
  assign bus.m_wstrb_o  = (state_reg == REQ) ? g_wstrb : '0;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign bus.s_ready_o[gi]  = req_active && bus.m_ready_i && (g_reg == GW'(gi));
      assign bus.s_rvalid_o[gi] = rd_done && (g_reg == GW'(gi));
      assign bus.s_rdata_o[gi*DATA_W +: DATA_W] =
        (rd_done && (g_reg == GW'(gi))) ? rd_data : '0;
    end
  endgenerate

`ifdef IOB_HOST_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);

  logic [WW-1:0] wd_reg;
  logic          err_reg;

  // Fires once TIMEOUT_CYC whole cycles have passed in WAIT_RD; a late rvalid still wins.
  assign timeout = (state_reg == WAIT_RD) && !bus.m_rvalid_i && (wd_reg == WW'(TIMEOUT_CYC));
  assign err_o   = err_reg;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wd_reg  <= '0;
      err_reg <= 1'b0;
    end else begin
      wd_reg <= ((state_reg == WAIT_RD) && !rd_done) ? wd_reg + 1'b1 : '0;
      if (timeout) err_reg <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif
endmodule

// File: tb/tb_iob_host_arb.sv
// Self-checking bench for iob_host_arb: directed scenarios plus a randomized run
// compared cycle by cycle against a transaction-level model of the arbitration rules.
module tb_iob_host_arb;
  localparam int N  = 2;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;
`ifdef IOB_HOST_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic arst;
  logic err;
  int   tests = 0;
  int   fails = 0;

  iob_host_arb_if #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW)) bus();

  iob_host_arb #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk_i (clk),
    .arst_i(arst),
    .bus   (bus),
    .err_o (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.s_avalid_i = '0;
    bus.s_addr_i   = '0;
    bus.s_wdata_i  = '0;
    bus.s_wstrb_i  = '0;
    bus.m_rdata_i  = '0;
    bus.m_rvalid_i = 1'b0;
    bus.m_ready_i  = 1'b0;
  endtask

  task automatic set_ch(input int ch, input logic v, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [SW-1:0] s);
    bus.s_avalid_i[ch]         = v;
    bus.s_addr_i[ch*AW +: AW]  = a;
    bus.s_wdata_i[ch*DW +: DW] = d;
    bus.s_wstrb_i[ch*SW +: SW] = s;
  endtask

  task automatic do_reset();
    idle_inputs();
    arst = 1'b1;
    step();
    step();
    arst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.s_avalid_i = '1;
    bus.m_rvalid_i = 1'b1;
    bus.m_ready_i  = 1'b1;
    bus.m_rdata_i  = $urandom;
    step();
    step();
    tests++; if (bus.m_avalid_o !== 1'b0) begin fails++; $display("FAIL rst_m_avalid got=%0b exp=0", bus.m_avalid_o); end
    tests++; if (bus.m_addr_o !== '0) begin fails++; $display("FAIL rst_m_addr got=%h exp=0", bus.m_addr_o); end
    tests++; if (bus.m_wdata_o !== '0) begin fails++; $display("FAIL rst_m_wdata got=%h exp=0", bus.m_wdata_o); end
    tests++; if (bus.m_wstrb_o !== '0) begin fails++; $display("FAIL rst_m_wstrb got=%h exp=0", bus.m_wstrb_o); end
    tests++; if (bus.s_ready_o !== '0) begin fails++; $display("FAIL rst_s_ready got=%b exp=0", bus.s_ready_o); end
    tests++; if (bus.s_rvalid_o !== '0) begin fails++; $display("FAIL rst_s_rvalid got=%b exp=0", bus.s_rvalid_o); end
    tests++; if (bus.s_rdata_o !== '0) begin fails++; $display("FAIL rst_s_rdata got=%h exp=0", bus.s_rdata_o); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err got=%b exp=0", err); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_read_both();
    do_reset();
    set_ch(0, 1'b1, 16'h0010, '0, '0);
    set_ch(1, 1'b1, 16'h0010, '0, '0);
    bus.m_ready_i = 1'b1;
    #1;
    tests++; if (bus.m_avalid_o !== 1'b0) begin fails++; $display("FAIL rb_idle m_avalid got=%0b exp=0", bus.m_avalid_o); end
    step(); #1;
    tests++; if (bus.m_avalid_o !== 1'b1) begin fails++; $display("FAIL rb_req0 m_avalid got=%0b exp=1", bus.m_avalid_o); end
    tests++; if (bus.m_addr_o !== 16'h0010) begin fails++; $display("FAIL rb_req0 m_addr got=%h exp=0010", bus.m_addr_o); end
    tests++; if (bus.s_ready_o !== 2'b01) begin fails++; $display("FAIL rb_req0 s_ready got=%b exp=01", bus.s_ready_o); end
    step();
    bus.s_avalid_i[0] = 1'b0;
    bus.m_rvalid_i    = 1'b1;
    bus.m_rdata_i     = 32'h12345678;
    #1;
    tests++; if (bus.s_rvalid_o !== 2'b01) begin fails++; $display("FAIL rb_rd0 s_rvalid got=%b exp=01", bus.s_rvalid_o); end
    tests++; if (bus.s_rdata_o !== {32'h0, 32'h12345678}) begin fails++; $display("FAIL rb_rd0 s_rdata got=%h exp=0000000012345678", bus.s_rdata_o); end
    tests++; if (bus.m_avalid_o !== 1'b0) begin fails++; $display("FAIL rb_rd0 m_avalid got=%0b exp=0", bus.m_avalid_o); end
    step(); #1;
    tests++; if (bus.s_rvalid_o !== 2'b00) begin fails++; $display("FAIL rb_pulse0 s_rvalid got=%b exp=00", bus.s_rvalid_o); end
    step();
    bus.m_rvalid_i = 1'b0;
    #1;
    tests++; if (bus.s_ready_o !== 2'b10) begin fails++; $display("FAIL rb_req1 s_ready got=%b exp=10", bus.s_ready_o); end
    step();
    bus.s_avalid_i[1] = 1'b0;
    bus.m_rvalid_i    = 1'b1;
    #1;
    tests++; if (bus.s_rvalid_o !== 2'b10) begin fails++; $display("FAIL rb_rd1 s_rvalid got=%b exp=10", bus.s_rvalid_o); end
    tests++; if (bus.s_rdata_o !== {32'h12345678, 32'h0}) begin fails++; $display("FAIL rb_rd1 s_rdata got=%h exp=1234567800000000", bus.s_rdata_o); end
    step();
    bus.m_rvalid_i = 1'b0;
    #1;
    tests++; if (bus.s_rvalid_o !== 2'b00) begin fails++; $display("FAIL rb_pulse1 s_rvalid got=%b exp=00", bus.s_rvalid_o); end
    $display("[TB] test_read_both done");
  endtask

  task automatic test_write_stall();
    do_reset();
    set_ch(1, 1'b1, 16'h0004, 32'hA5A5A5A5, 4'hF);
    step();
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++; if (bus.m_avalid_o !== 1'b1) begin fails++; $display("FAIL ws_stall%0d m_avalid got=%0b exp=1", k, bus.m_avalid_o); end
      tests++; if (bus.m_addr_o !== 16'h0004) begin fails++; $display("FAIL ws_stall%0d m_addr got=%h exp=0004", k, bus.m_addr_o); end
      tests++; if (bus.m_wdata_o !== 32'hA5A5A5A5) begin fails++; $display("FAIL ws_stall%0d m_wdata got=%h exp=a5a5a5a5", k, bus.m_wdata_o); end
      tests++; if (bus.m_wstrb_o !== 4'hF) begin fails++; $display("FAIL ws_stall%0d m_wstrb got=%h exp=f", k, bus.m_wstrb_o); end
      tests++; if (bus.s_ready_o !== 2'b00) begin fails++; $display("FAIL ws_stall%0d s_ready got=%b exp=00", k, bus.s_ready_o); end
      step();
    end
    bus.m_ready_i = 1'b1;
    #1;
    tests++; if (bus.s_ready_o !== 2'b10) begin fails++; $display("FAIL ws_accept s_ready got=%b exp=10", bus.s_ready_o); end
    step();
    bus.s_avalid_i[1] = 1'b0;
    bus.m_rvalid_i    = 1'b1;
    #1;
    tests++; if (bus.m_avalid_o !== 1'b0) begin fails++; $display("FAIL ws_after m_avalid got=%0b exp=0", bus.m_avalid_o); end
    tests++; if (bus.s_rvalid_o !== 2'b00) begin fails++; $display("FAIL ws_after s_rvalid got=%b exp=00", bus.s_rvalid_o); end
    step(); #1;
    tests++; if (bus.s_rvalid_o !== 2'b00) begin fails++; $display("FAIL ws_after2 s_rvalid got=%b exp=00", bus.s_rvalid_o); end
    bus.m_rvalid_i = 1'b0;
    $display("[TB] test_write_stall done");
  endtask

  task automatic test_fairness();
    do_reset();
    set_ch(0, 1'b1, 16'h0100, 32'h11, 4'h1);
    bus.m_ready_i = 1'b1;
    step();
    set_ch(1, 1'b1, 16'h0200, 32'h22, 4'h3);
    #1;
    tests++; if (bus.s_ready_o !== 2'b01) begin fails++; $display("FAIL fair_first s_ready got=%b exp=01", bus.s_ready_o); end
    step(); #1;
    tests++; if (bus.m_avalid_o !== 1'b0) begin fails++; $display("FAIL fair_gap m_avalid got=%0b exp=0", bus.m_avalid_o); end
    step(); #1;
    tests++; if (bus.s_ready_o !== 2'b10) begin fails++; $display("FAIL fair_ch1 s_ready got=%b exp=10", bus.s_ready_o); end
    tests++; if (bus.m_addr_o !== 16'h0200) begin fails++; $display("FAIL fair_ch1 m_addr got=%h exp=0200", bus.m_addr_o); end
    step();
    bus.s_avalid_i[1] = 1'b0;
    #1;
    tests++; if (bus.m_avalid_o !== 1'b0) begin fails++; $display("FAIL fair_gap2 m_avalid got=%0b exp=0", bus.m_avalid_o); end
    step(); #1;
    tests++; if (bus.s_ready_o !== 2'b01) begin fails++; $display("FAIL fair_ch0_again s_ready got=%b exp=01", bus.s_ready_o); end
    $display("[TB] test_fairness done");
  endtask

  task automatic test_abort();
    do_reset();
    set_ch(0, 1'b1, 16'h0030, '0, '0);
    set_ch(1, 1'b0, 16'h0040, '0, '0);
    step(); #1;
    tests++; if (bus.m_avalid_o !== 1'b1) begin fails++; $display("FAIL ab_req m_avalid got=%0b exp=1", bus.m_avalid_o); end
    bus.s_avalid_i[0] = 1'b0;
    #1;
    tests++; if (bus.m_avalid_o !== 1'b0) begin fails++; $display("FAIL ab_drop m_avalid got=%0b exp=0", bus.m_avalid_o); end
    tests++; if (bus.s_ready_o !== 2'b00) begin fails++; $display("FAIL ab_drop s_ready got=%b exp=00", bus.s_ready_o); end
    step();
    bus.s_avalid_i = 2'b11;
    #1;
    tests++; if (bus.m_avalid_o !== 1'b0) begin fails++; $display("FAIL ab_idle m_avalid got=%0b exp=0", bus.m_avalid_o); end
    step(); #1;
    tests++; if (bus.m_avalid_o !== 1'b1) begin fails++; $display("FAIL ab_regrant m_avalid got=%0b exp=1", bus.m_avalid_o); end
    tests++; if (bus.m_addr_o !== 16'h0030) begin fails++; $display("FAIL ab_regrant m_addr got=%h exp=0030", bus.m_addr_o); end
    $display("[TB] test_abort done");
  endtask

  task automatic test_reset_midread();
    do_reset();
    set_ch(0, 1'b1, 16'h0050, '0, '0);
    bus.m_ready_i = 1'b1;
    step();
    step();
    bus.s_avalid_i[0] = 1'b0;
    bus.m_rvalid_i    = 1'b1;
    bus.m_rdata_i     = 32'hCAFEF00D;
    #1;
    tests++; if (bus.s_rvalid_o !== 2'b01) begin fails++; $display("FAIL rm_pre s_rvalid got=%b exp=01", bus.s_rvalid_o); end
    arst = 1'b1;
    #1;
    tests++; if (bus.s_rvalid_o !== 2'b00) begin fails++; $display("FAIL rm_async s_rvalid got=%b exp=00", bus.s_rvalid_o); end
    tests++; if (bus.s_rdata_o !== '0) begin fails++; $display("FAIL rm_async s_rdata got=%h exp=0", bus.s_rdata_o); end
    tests++; if (bus.m_avalid_o !== 1'b0) begin fails++; $display("FAIL rm_async m_avalid got=%0b exp=0", bus.m_avalid_o); end
    step();
    arst = 1'b0;
    #1;
    tests++; if (bus.s_rvalid_o !== 2'b00) begin fails++; $display("FAIL rm_late s_rvalid got=%b exp=00", bus.s_rvalid_o); end
    bus.m_rvalid_i = 1'b0;
    set_ch(0, 1'b1, 16'h0060, '0, '0);
    set_ch(1, 1'b1, 16'h0070, '0, '0);
    step(); #1;
    tests++; if (bus.m_avalid_o !== 1'b1) begin fails++; $display("FAIL rm_first_edge m_avalid got=%0b exp=1", bus.m_avalid_o); end
    tests++; if (bus.s_ready_o !== 2'b01) begin fails++; $display("FAIL rm_ptr_reset s_ready got=%b exp=01", bus.s_ready_o); end
    $display("[TB] test_reset_midread done");
  endtask

  task automatic test_timeout();
    bit exp_rv;
    bit exp_err;
    do_reset();
    set_ch(0, 1'b1, 16'h0080, '0, '0);
    bus.m_ready_i = 1'b1;
    step();
    step();
    bus.s_avalid_i = '0;
    bus.m_ready_i  = 1'b0;
    for (int k = 1; k <= TO + 4; k++) begin
      #1;
      exp_rv  = TO_EN && (k == TO + 1);
      exp_err = TO_EN && (k > TO + 1);
      tests++; if (bus.s_rvalid_o[0] !== exp_rv) begin fails++; $display("FAIL to_cyc%0d s_rvalid got=%b exp=%b", k, bus.s_rvalid_o[0], exp_rv); end
      if (exp_rv) begin
        tests++; if (bus.s_rdata_o[DW-1:0] !== 32'hFFFFFFFF) begin fails++; $display("FAIL to_cyc%0d s_rdata got=%h exp=ffffffff", k, bus.s_rdata_o[DW-1:0]); end
      end
      tests++; if (err !== exp_err) begin fails++; $display("FAIL to_cyc%0d err got=%b exp=%b", k, err, exp_err); end
      step();
    end
    $display("[TB] test_timeout done (watchdog %s)", TO_EN ? "enabled" : "disabled");
  endtask

  task automatic test_random();
    int            mp, mg, mwait;
    bit            mpres, mread, merr;
    logic [N-1:0]  acc;
    logic          e_mav;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [SW-1:0] e_ws;
    logic [N-1:0]  e_rdy, e_rv;
    logic [N*DW-1:0] e_rd;
    do_reset();
    mp = 0; mg = 0; mwait = 0; mpres = 0; mread = 0; merr = 0; acc = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (bus.s_avalid_i[ch]) begin
          if (acc[ch] || $urandom_range(0, 15) == 0) bus.s_avalid_i[ch] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          set_ch(ch, 1'b1, AW'($urandom), $urandom,
                 ($urandom_range(0, 1) != 0) ? SW'($urandom_range(1, 15)) : '0);
        end
      end
      bus.m_ready_i  = ($urandom_range(0, 1) != 0);
      bus.m_rvalid_i = ($urandom_range(0, 2) == 0);
      bus.m_rdata_i  = $urandom;
      #1;
      e_mav = 1'b0; e_addr = '0; e_wd = '0; e_ws = '0; e_rdy = '0; e_rv = '0; e_rd = '0;
      if (mpres) begin
        e_mav       = bus.s_avalid_i[mg];
        e_addr      = bus.s_addr_i[mg*AW +: AW];
        e_wd        = bus.s_wdata_i[mg*DW +: DW];
        e_ws        = bus.s_wstrb_i[mg*SW +: SW];
        e_rdy[mg]   = bus.s_avalid_i[mg] && bus.m_ready_i;
      end else if (mread) begin
        if (bus.m_rvalid_i) begin
          e_rv[mg] = 1'b1;
          e_rd[mg*DW +: DW] = bus.m_rdata_i;
        end else if (TO_EN && mwait == TO) begin
          e_rv[mg] = 1'b1;
          e_rd[mg*DW +: DW] = '1;
        end
      end
      tests++; if (bus.m_avalid_o !== e_mav) begin fails++; $display("FAIL rnd%0d m_avalid got=%b exp=%b", cyc, bus.m_avalid_o, e_mav); end
      tests++; if (bus.m_addr_o !== e_addr) begin fails++; $display("FAIL rnd%0d m_addr got=%h exp=%h", cyc, bus.m_addr_o, e_addr); end
      tests++; if (bus.m_wdata_o !== e_wd) begin fails++; $display("FAIL rnd%0d m_wdata got=%h exp=%h", cyc, bus.m_wdata_o, e_wd); end
      tests++; if (bus.m_wstrb_o !== e_ws) begin fails++; $display("FAIL rnd%0d m_wstrb got=%h exp=%h", cyc, bus.m_wstrb_o, e_ws); end
      tests++; if (bus.s_ready_o !== e_rdy) begin fails++; $display("FAIL rnd%0d s_ready got=%b exp=%b", cyc, bus.s_ready_o, e_rdy); end
      tests++; if (bus.s_rvalid_o !== e_rv) begin fails++; $display("FAIL rnd%0d s_rvalid got=%b exp=%b", cyc, bus.s_rvalid_o, e_rv); end
      tests++; if (bus.s_rdata_o !== e_rd) begin fails++; $display("FAIL rnd%0d s_rdata got=%h exp=%h", cyc, bus.s_rdata_o, e_rd); end
      tests++; if (err !== merr) begin fails++; $display("FAIL rnd%0d err got=%b exp=%b", cyc, err, merr); end
      // Advance the transaction-level model across the coming clock edge.
      if (mpres) begin
        if (!bus.s_avalid_i[mg]) begin
          mpres = 0;
        end else if (bus.m_ready_i) begin
          mp    = (mg + 1) % N;
          mpres = 0;
          mread = (bus.s_wstrb_i[mg*SW +: SW] == '0);
          mwait = 0;
        end
      end else if (mread) begin
        if (e_rv[mg]) begin
          mread = 0;
          if (!bus.m_rvalid_i) merr = 1;
        end else begin
          mwait++;
        end
      end else if (bus.s_avalid_i != '0) begin
        for (int k = 0; k < N; k++) begin
          if (bus.s_avalid_i[(mp + k) % N]) begin
            mg = (mp + k) % N;
            break;
          end
        end
        mpres = 1;
      end
      acc = e_rdy;
      step();
    end
    $display("[TB] test_random done");
  endtask

  initial begin
    arst = 1'b1;
    idle_inputs();
    test_reset();
    test_read_both();
    test_write_stall();
    test_fairness();
    test_abort();
    test_reset_midread();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/iob_host_arb.md
IOB_HOST_ARB -- requirements
Module: iob_host_arb

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of host channels, range 1..16.
REQ-002 SHALL have parameter ADDR_W, default 16: IOb address width.
REQ-003 SHALL have parameter DATA_W, default 32: IOb data width; strobe width is DATA_W/8.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1024: read watchdog limit in cycles.
REQ-005 SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port arst_i, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port s_avalid_i, input, N_CH: per-channel request valid.
REQ-008 SHALL have port s_addr_i, input, N_CH*ADDR_W: per-channel address, channel k at bits [k*ADDR_W +: ADDR_W].
REQ-009 SHALL have port s_wdata_i, input, N_CH*DATA_W: per-channel write data.
REQ-010 SHALL have port s_wstrb_i, input, N_CH*DATA_W/8: per-channel strobes; all-zero means read.
REQ-011 SHALL have port s_rdata_o, output, N_CH*DATA_W: per-channel read data.
REQ-012 SHALL have ports s_ready_o and s_rvalid_o, each output, N_CH: per-channel accept and read-valid.
REQ-013 SHALL have ports m_avalid_o (1), m_addr_o (ADDR_W), m_wdata_o (DATA_W), m_wstrb_o (DATA_W/8), all outputs: shared manager request.
REQ-014 SHALL have ports m_rdata_i (DATA_W), m_rvalid_i (1), m_ready_i (1), all inputs: shared manager response.
REQ-015 SHALL have port err_o, output, 1: sticky read-timeout flag.

Function
REQ-016 SHALL implement states IDLE, REQ, WAIT_RD, plus a registered grant index g and a round-robin pointer p, each $clog2(N_CH) bits wide with minimum width 1.
REQ-017 In IDLE, when any s_avalid_i bit is set, SHALL register g as the first set bit searched from p upward with wrap N_CH-1 -> 0, and enter REQ the next cycle.
REQ-018 In REQ, SHALL drive m_avalid_o=1 and m_addr_o/m_wdata_o/m_wstrb_o combinationally from channel g; all m_* outputs SHALL be 0 outside REQ.
REQ-019 In REQ, SHALL drive s_ready_o[g] equal to m_ready_i in the same cycle; all other s_ready_o bits SHALL be 0.
REQ-020 On m_ready_i in REQ, SHALL update p to g+1 (wrapping N_CH-1 -> 0), then go to WAIT_RD if the wstrb of channel g is zero, else to IDLE.
REQ-021 If s_avalid_i[g] drops in REQ without m_ready_i, SHALL abort: m_avalid_o=0 that cycle, return to IDLE, leave p unchanged.
REQ-022 In WAIT_RD, on m_rvalid_i SHALL pulse s_rvalid_o[g] for one cycle with s_rdata_o[g]=m_rdata_i, then return to IDLE.
REQ-023 s_rdata_o of non-granted channels SHALL be 0; m_rvalid_i outside WAIT_RD SHALL be ignored.
REQ-024 Request-to-m_avalid_o latency SHALL be exactly 1 cycle; back-to-back transactions SHALL leave at least one IDLE cycle between them.
REQ-025 A new request from a channel whose read is outstanding SHALL NOT be granted until WAIT_RD completes.

Reset
REQ-026 While arst_i=1, SHALL force state=IDLE, g=0, p=0, err_o=0, watchdog=0, and all s_* and m_* outputs to 0, regardless of any transaction in flight.
REQ-027 After arst_i deasserts, SHALL accept a new request on the first rising edge.

Configuration
REQ-028 Macro IOB_HOST_ARB_TIMEOUT_EN SHALL enable the read watchdog when defined.
REQ-029 With IOB_HOST_ARB_TIMEOUT_EN defined, in WAIT_RD SHALL count cycles and, if TIMEOUT_CYC elapse without m_rvalid_i, pulse s_rvalid_o[g] with s_rdata_o[g] all-ones, set err_o (cleared only by reset), and return to IDLE.
REQ-030 Without IOB_HOST_ARB_TIMEOUT_EN, WAIT_RD SHALL wait indefinitely, err_o SHALL be tied 0, and no counter SHALL be synthesised.

Verification
REQ-031 N_CH=2, both channels request a read to 0x0010 at once, m_ready_i=1, m_rvalid_i one cycle later with 0x12345678 -> ch0 served first, ch1 next, each receives 0x12345678 with a single-cycle s_rvalid_o pulse.
REQ-032 ch1 issues a write of 0xA5A5A5A5, wstrb 0xF, to 0x0004, m_ready_i held 0 for 3 cycles -> m_avalid_o stays high 3 cycles, s_ready_o[1] pulses on the accept cycle, no s_rvalid_o.
REQ-033 ch0 requests continuously, ch1 requests once, after ch0's first grant -> ch1 is granted next (p=1), and ch0 does not starve.
REQ-034 Read granted, arst_i pulsed in WAIT_RD -> all outputs 0 asynchronously, p=0, and a later m_rvalid_i produces no s_rvalid_o.
REQ-035 With IOB_HOST_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, read with no m_rvalid_i -> after 8 cycles s_rdata_o=0xFFFFFFFF, s_rvalid_o pulses, and err_o=1 sticky.
REQ-036 ch0 drops s_avalid_i in REQ before m_ready_i -> abort to IDLE, p unchanged, no s_ready_o pulse.
